// File: rtl/v_instr_issue.sv
// v_instr_issue: buffers vector instructions with their rs1 operand and issues them
// one at a time to the vector coprocessor, with a watchdog for hung instructions.
//
// state  | meaning
// S_IDLE | nothing presented; pops the FIFO head when one is waiting
// S_EXEC | cur instruction presented to the coprocessor until it retires
module v_instr_issue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [31:0]            in_xdata,
    input  logic                   flush,
    output logic [31:0]            cp_instr,
    output logic [31:0]            cp_xdata,
    output logic                   cp_valid,
    input  logic                   cp_done,
    output logic                   retired,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [31:0]   r_mem_instr [DEPTH];
    logic [31:0]   r_mem_xdata [DEPTH];

    logic [31:0]   r_cur_instr;
    logic [31:0]   r_cur_xdata;
    logic [TW-1:0] r_timer;
    logic          r_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_cur_cfg;
    logic          w_retire;
    logic          w_timeout_hit;

    // Full when the pointers agree on the index but differ in the wrap bit.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    assign in_ready = !w_full && !flush;
    assign w_push   = in_valid && in_ready;

    // vsetvli-class: OP-V major opcode with funct3 = OPCFG.
    assign w_cur_cfg = (r_cur_instr[6:0] == 7'b1010111) &&
                       (r_cur_instr[14:12] == 3'b111);

    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_retire      = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_cur_cfg || cp_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timeout_hit = 1'b1;
                    w_retire      = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Aborted work (flush or reset) never reports a retirement.
        if (flush || nrst) begin
            w_pop         = 1'b0;
            w_retire      = 1'b0;
            w_timeout_hit = 1'b0;
            w_state_nxt   = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
            end
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr[AW-1:0]] <= in_instr;
            r_mem_xdata[r_wr_ptr[AW-1:0]] <= in_xdata;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst || flush) begin
            r_cur_instr <= '0;
            r_cur_xdata <= '0;
        end else if (w_pop) begin
            r_cur_instr <= r_mem_instr[r_rd_ptr[AW-1:0]];
            r_cur_xdata <= r_mem_xdata[r_rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (nrst || flush || w_pop) begin
            r_timer <= '0;
        end else if (r_state == S_EXEC && !w_retire) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_err <= 1'b0;
        end else if (w_timeout_hit) begin
            r_err <= 1'b1;
        end
    end

    assign cp_valid    = (r_state == S_EXEC);
    assign cp_instr    = cp_valid ? r_cur_instr : 32'h0;
    assign cp_xdata    = cp_valid ? r_cur_xdata : 32'h0;
    assign retired     = w_retire;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign count       = r_wr_ptr - r_rd_ptr;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_v_instr_issue.sv
// tb_v_instr_issue: directed vector table, hand sequences for the multi-cycle
// corners, then random traffic against a queue-based reference model.
module tb_v_instr_issue;
    localparam int          DEPTH   = 4;
    localparam int          TIMEOUT = 64;
    localparam logic [31:0] VADD    = 32'h0220_8157;
    localparam logic [31:0] VSET    = 32'h0085_7057;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_xdata;
    logic        flush;
    logic [31:0] cp_instr;
    logic [31:0] cp_xdata;
    logic        cp_valid;
    logic        cp_done;
    logic        retired;
    logic        busy;
    logic [2:0]  count;
    logic        err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    v_instr_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_xdata(in_xdata), .flush(flush),
        .cp_instr(cp_instr), .cp_xdata(cp_xdata), .cp_valid(cp_valid),
        .cp_done(cp_done), .retired(retired), .busy(busy), .count(count),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] xd;
        logic        fl;
        logic        dn;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_ins;
        logic [31:0] e_xd;
        logic        e_ret;
        logic        e_busy;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl[14];

    // reference model state
    logic [63:0] mq[$];
    logic        m_exec;
    logic [31:0] m_cur_i;
    logic [31:0] m_cur_x;
    int          m_age;
    logic        m_err;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] xd,
                         input logic fl, input logic dn);
        in_valid = v;
        in_instr = ins;
        in_xdata = xd;
        flush    = fl;
        cp_done  = dn;
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        nrst = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b1);
        chk1({tag, "_cp_valid"}, cp_valid, 1'b0);
        chk32({tag, "_cp_instr"}, cp_instr, 32'h0);
        chk32({tag, "_cp_xdata"}, cp_xdata, 32'h0);
        chk1({tag, "_retired"}, retired, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk32({tag, "_count"}, 32'(count), 32'd0);
        chk1({tag, "_err"}, err_timeout, 1'b0);
    endtask

    function automatic logic [31:0] mc_word(input int i);
        return 32'h0000_0057 | (32'(i + 1) << 20);
    endfunction

    function automatic logic is_cfg(input logic [31:0] w);
        return (w[6:0] == 7'b1010111) && (w[14:12] == 3'b111);
    endfunction

    initial begin
        int got;
        int execs;
        int ret_at;
        int done_pct;
        int pcts[4];
        logic        r_rst, r_v, r_fl, r_dn, e_full, hit, do_push;
        logic [31:0] r_ins, r_xd;
        logic [63:0] ent;

        nrst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        //        v     ins   xd      fl    dn    rdy   val   e_ins e_xd   ret   busy  cnt
        tbl[0]  = '{1'b1, VADD, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 3'd1};
        tbl[2]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, VADD, 32'd5, 1'b0, 1'b1, 3'd0};
        tbl[3]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, VADD, 32'd5, 1'b0, 1'b1, 3'd0};
        tbl[4]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, VADD, 32'd5, 1'b0, 1'b1, 3'd0};
        tbl[5]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, VADD, 32'd5, 1'b1, 1'b1, 3'd0};
        tbl[6]  = '{1'b1, VSET, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 3'd1};
        tbl[8]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, VSET, 32'd9, 1'b1, 1'b1, 3'd0};
        tbl[9]  = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b1, VADD, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 3'd0};
        tbl[11] = '{1'b1, VSET, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b1, 3'd1};
        tbl[12] = '{1'b1, VADD, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, VADD, 32'd1, 1'b0, 1'b1, 3'd1};
        tbl[13] = '{1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 3'd0};

        do_reset();
        settle();
        check_reset_values("reset");
        step();

        // single vadd, vsetvli, cp_done in IDLE, flush with a push in the same cycle
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, tbl[i].ins, tbl[i].xd, tbl[i].fl, tbl[i].dn);
            settle();
            chk1($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
            chk1($sformatf("tbl%0d_cp_valid", i), cp_valid, tbl[i].e_val);
            chk32($sformatf("tbl%0d_cp_instr", i), cp_instr, tbl[i].e_ins);
            chk32($sformatf("tbl%0d_cp_xdata", i), cp_xdata, tbl[i].e_xd);
            chk1($sformatf("tbl%0d_retired", i), retired, tbl[i].e_ret);
            chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk32($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // fill: one in EXEC, four queued, sixth refused, then in-order issue
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, mc_word(i), 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'hDEAD_0057, 32'h0, 1'b0, 1'b0);
        settle();
        chk32("fill_count", 32'(count), 32'd4);
        chk1("fill_in_ready", in_ready, 1'b0);
        chk32("fill_cp_instr", cp_instr, mc_word(0));
        step();
        settle();
        chk32("fill_refused_count", 32'(count), 32'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            settle();
            if (cp_valid) begin
                chk32($sformatf("fill_order%0d", got), cp_instr, mc_word(got));
                chk32($sformatf("fill_xdata%0d", got), cp_xdata, 32'(got));
                got++;
                cp_done = 1'b1;
            end else begin
                cp_done = 1'b0;
            end
            step();
        end
        cp_done = 1'b0;
        chk32("fill_issued", 32'(got), 32'd5);
        settle();
        chk1("fill_drained", busy, 1'b0);
        step();

        // watchdog
        drive(1'b1, 32'h0400_0057, 32'd7, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        execs  = 0;
        ret_at = -1;
        for (int c = 0; c < 200; c++) begin
            settle();
            if (cp_valid) execs++;
            if (retired) begin
                ret_at = execs;
                chk1("wdog_err_before", err_timeout, 1'b0);
            end
            step();
            if (ret_at >= 0) break;
        end
        chk32("wdog_exec_cycles", 32'(ret_at), 32'd64);
        settle();
        chk1("wdog_err_set", err_timeout, 1'b1);
        chk1("wdog_idle", cp_valid, 1'b0);
        drive(1'b1, VSET, 32'd8, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        settle();
        chk32("wdog_next_issue", cp_instr, VSET);
        chk1("wdog_next_retired", retired, 1'b1);
        chk1("wdog_err_sticky", err_timeout, 1'b1);
        step();

        // flush with 3 queued + 1 in EXEC, push and cp_done in the same cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mc_word(i + 10), 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        settle();
        chk32("flush_pre_count", 32'(count), 32'd3);
        chk1("flush_pre_valid", cp_valid, 1'b1);
        drive(1'b1, 32'hBEEF_0057, 32'h0, 1'b1, 1'b1);
        #1;
        chk1("flush_in_ready", in_ready, 1'b0);
        chk1("flush_no_retire", retired, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        settle();
        chk32("flush_count", 32'(count), 32'd0);
        chk1("flush_valid", cp_valid, 1'b0);
        chk32("flush_cp_instr", cp_instr, 32'h0);
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_retired", retired, 1'b0);
        step();
        settle();
        chk1("flush_dropped", busy, 1'b0);
        step();

        // simultaneous push/pop at count=2, then reset mid-EXEC
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mc_word(i + 20), 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        settle();
        chk32("pp_pre_count", 32'(count), 32'd2);
        chk32("pp_exec_a", cp_instr, mc_word(20));
        cp_done = 1'b1;
        step();
        drive(1'b1, mc_word(23), 32'd3, 1'b0, 1'b0);
        settle();
        chk1("pp_idle", cp_valid, 1'b0);
        chk1("pp_in_ready", in_ready, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        settle();
        chk32("pp_count", 32'(count), 32'd2);
        chk32("pp_exec_b", cp_instr, mc_word(21));
        nrst = 1'b1;
        cp_done = 1'b1;
        #1;
        chk1("rst_no_retire", retired, 1'b0);
        step();
        nrst = 1'b0;
        cp_done = 1'b0;
        settle();
        check_reset_values("rst_exec");
        step();

        // random traffic against the reference model
        do_reset();
        mq.delete();
        m_exec   = 1'b0;
        m_cur_i  = 32'h0;
        m_cur_x  = 32'h0;
        m_age    = 0;
        m_err    = 1'b0;
        pcts     = '{0, 10, 35, 70};
        done_pct = 35;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) done_pct = pcts[$urandom_range(0, 3)];
            r_rst = ($urandom_range(0, 199) == 0);
            r_v   = 1'($urandom_range(0, 1));
            r_ins = $urandom;
            if ($urandom_range(0, 3) == 0) r_ins = {r_ins[31:15], 3'b111, r_ins[11:7], 7'b1010111};
            r_xd  = $urandom;
            r_fl  = ($urandom_range(0, 39) == 0);
            r_dn  = ($urandom_range(0, 99) < done_pct);
            nrst  = r_rst;
            drive(r_v, r_ins, r_xd, r_fl, r_dn);
            settle();

            e_full = (mq.size() == DEPTH);
            hit    = m_exec && (is_cfg(m_cur_i) || r_dn || m_age == TIMEOUT - 1);
            chk1("rnd_in_ready", in_ready, !e_full && !r_fl);
            chk1("rnd_cp_valid", cp_valid, m_exec);
            chk32("rnd_cp_instr", cp_instr, m_exec ? m_cur_i : 32'h0);
            chk32("rnd_cp_xdata", cp_xdata, m_exec ? m_cur_x : 32'h0);
            chk1("rnd_retired", retired, hit && !r_fl && !r_rst);
            chk1("rnd_busy", busy, m_exec || mq.size() != 0);
            chk32("rnd_count", 32'(count), 32'(mq.size()));
            chk1("rnd_err", err_timeout, m_err);

            if (r_rst) begin
                mq.delete();
                m_exec = 1'b0;
                m_err  = 1'b0;
                m_age  = 0;
            end else if (r_fl) begin
                mq.delete();
                m_exec = 1'b0;
            end else begin
                do_push = r_v && !e_full;
                if (m_exec) begin
                    if (hit) begin
                        if (!is_cfg(m_cur_i) && !r_dn) m_err = 1'b1;
                        m_exec = 1'b0;
                    end else begin
                        m_age++;
                    end
                end else if (mq.size() > 0) begin
                    ent     = mq.pop_front();
                    m_cur_i = ent[63:32];
                    m_cur_x = ent[31:0];
                    m_exec  = 1'b1;
                    m_age   = 0;
                end
                if (do_push) mq.push_back({r_ins, r_xd});
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
